// File: rtl/pc_unit_ras.sv
// Fetch program counter with stall, branch, call/return and a circular
// return-address stack; pc and all flags are registered.
module pc_unit_ras #(
    parameter int               WIDTH     = 32,
    parameter int               STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               RAS_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             stall,
    input  logic                             branch,
    input  logic                             call,
    input  logic                             ret,
    input  logic [WIDTH-1:0]                 target,
    output logic [WIDTH-1:0]                 pc,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_overflow,
    output logic                             ras_underflow
);

    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push;
    logic [WIDTH-1:0] pc_inc;
    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    next_idx;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    // ptr_q points at the next free slot; the top entry sits just below it.
    always_comb begin
        pc_inc   = pc_q + WIDTH'(STEP);
        top_idx  = (ptr_q == '0) ? PW'(RAS_DEPTH - 1) : ptr_q - PW'(1);
        next_idx = (ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        ovf_d    = ovf_q;
        unf_d    = 1'b0;
        push     = 1'b0;
        if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (cnt_q != '0) begin
                pc_d  = ras_q[top_idx];
                cnt_d = cnt_q - CW'(1);
                ptr_d = top_idx;
            end else begin
                pc_d  = pc_inc;
                unf_d = 1'b1;
            end
        end else if (call) begin
            push  = 1'b1;
            pc_d  = target;
            ptr_d = next_idx;
            // When full, the free slot is the oldest entry, so it gets overwritten.
            if (cnt_q == CW'(RAS_DEPTH)) ovf_d = 1'b1;
            else                         cnt_d = cnt_q + CW'(1);
        end else if (branch) begin
            pc_d = target;
        end else begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
            ptr_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) ras_q[ptr_q] <= pc_inc;
    end

    assign pc            = pc_q;
    assign ras_count     = cnt_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule
